// File: rtl/cpu_pkg.sv
// Shared CPU types for the dynamic branch predictor.
//   bp_cnt_t    : 2-bit saturating direction counter state
//   btb_entry_t : one branch target buffer entry (tag is zero-extended to 32b)
//   bp_next     : next counter state for a resolved branch/jump
package cpu_pkg;

  localparam int BP_INDEX_BITS_DEFAULT = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Jumps are unconditional, so they go straight to strongly taken.
  function automatic bp_cnt_t bp_next(input bp_cnt_t cur, input logic taken,
                                      input logic jump);
    bp_cnt_t nxt;
    nxt = cur;
    if (jump) begin
      nxt = ST;
    end else if (taken) begin
      case (cur)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        default: nxt = ST;
      endcase
    end else begin
      case (cur)
        ST:      nxt = WT;
        WT:      nxt = WNT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer storage.
//   clk, rst  : clock, synchronous active-high reset (clears valid bits only)
//   rd_idx    : combinational read index -> rd_entry
//   wr_en     : synchronous write of wr_entry at wr_idx
module btb_table
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output btb_entry_t            rd_entry,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t            wr_entry
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic        valid_q  [DEPTH];
  logic [31:0] tag_q    [DEPTH];
  logic [31:0] target_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  // Tag/target need no reset: they are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = tag_q[rd_idx];
    rd_entry.target = target_q[rd_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counters plus direct-mapped BTB.
//   clk, rst                   : clock, synchronous active-high reset
//   PC_IF                      : fetch PC, looked up combinationally
//   PC_enable, Flush_IFID      : hazard-unit control of the IF/ID slot
//   branch_ID, jump_ID         : decode instruction class
//   TakeBranch_ID, BranchTarget_ID : resolved outcome in decode
//   incorrect_b_prediction     : hazard unit mispredict flag
//   predict_taken_IF/target_IF : fetch prediction (target 0 if not taken)
//   predict_branch_taken_ID    : prediction carried with the decode slot
//   branch_count, mispredict_count : wrapping statistics
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_IF,
  input  logic             PC_enable,
  input  logic             Flush_IFID,
  input  logic             branch_ID,
  input  logic             jump_ID,
  input  logic             TakeBranch_ID,
  input  logic [31:0]      BranchTarget_ID,
  input  logic             incorrect_b_prediction,
  output logic             predict_taken_IF,
  output logic [31:0]      predict_target_IF,
  output logic             predict_branch_taken_ID,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic                  unused_pc_lsbs;
  btb_entry_t            rd_entry;
  btb_entry_t            wr_entry;
  bp_cnt_t               cnt_q [DEPTH];

  logic                  slot_valid;
  logic [INDEX_BITS-1:0] slot_idx;
  logic [TAG_W-1:0]      slot_tag;
  logic                  slot_pred;

  logic                  train;
  logic                  taken_res;

  assign fetch_idx      = PC_IF[INDEX_BITS+1:2];
  assign fetch_tag      = PC_IF[31:INDEX_BITS+2];
  assign unused_pc_lsbs = ^PC_IF[1:0];

  // Lookup reads pre-edge state only; a same-cycle training write is not bypassed.
  assign predict_taken_IF  = (cnt_q[fetch_idx] inside {WT, ST}) && rd_entry.valid
                             && (rd_entry.tag == 32'(fetch_tag));
  assign predict_target_IF = predict_taken_IF ? rd_entry.target : 32'd0;

  assign train     = slot_valid && (branch_ID || jump_ID);
  assign taken_res = TakeBranch_ID || jump_ID;

  always_comb begin
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = 32'(slot_tag);
    wr_entry.target = BranchTarget_ID;
  end

  btb_table #(.INDEX_BITS(INDEX_BITS)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_idx),
    .rd_entry (rd_entry),
    .wr_en    (train && taken_res),
    .wr_idx   (slot_idx),
    .wr_entry (wr_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= WNT;
    end else if (train) begin
      cnt_q[slot_idx] <= bp_next(cnt_q[slot_idx], TakeBranch_ID, jump_ID);
    end
  end

  // IF/ID slot: flush beats advance; idx/tag are kept on flush since valid gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_idx   <= '0;
      slot_tag   <= '0;
      slot_pred  <= 1'b0;
    end else if (Flush_IFID) begin
      slot_valid <= 1'b0;
      slot_pred  <= 1'b0;
    end else if (PC_enable) begin
      slot_valid <= 1'b1;
      slot_idx   <= fetch_idx;
      slot_tag   <= fetch_tag;
      slot_pred  <= predict_taken_IF;
    end
  end

  assign predict_branch_taken_ID = slot_pred;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      branch_count <= branch_count + CNT_W'(1);
      if (incorrect_b_prediction) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
